// File: rtl/i2s_pkg.sv
// Shared frame timing constants and sample/FIFO entry types for the I2S transmit path.
package i2s_pkg;

    localparam int MCLK_PER_SCLK  = 4;
    localparam int SCLK_PER_FRAME = 64;
    localparam int FRAME_CLKS     = 256;
    localparam int LOAD_L         = 4;
    localparam int LOAD_R         = 132;
    localparam int SAMPLE_W       = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        logic    tlast;
        sample_t sample;
    } fifo_entry_t;

endpackage

// File: rtl/axis_sample_fifo.sv
// Small synchronous sample FIFO: one push and up to two pops per cycle,
// with the head and the entry behind it visible for frame-start decisions.
module axis_sample_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fifo_entry_t              push_data,
    input  logic [1:0]               pop_cnt,
    output fifo_entry_t              head,
    output fifo_entry_t              next_entry,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are power-of-two wide so they wrap without explicit compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            level  <= level + LVL_W'(push) - LVL_W'(pop_cnt);
        end
    end

    assign head       = mem[rd_ptr];
    assign next_entry = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/axis_i2s_tx.sv
// AXI-Stream to I2S line-out transmitter: requantizes FIR accumulator words to
// 24-bit samples, queues them and serializes one stereo frame every 256 MCLKs.
module axis_i2s_tx
    import i2s_pkg::*;
#(
    parameter int IN_WIDTH   = 52,
    parameter int OUT_WIDTH  = 24,
    parameter int FRAC_SHIFT = 23,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_WIDTH-1:0]           s_axis_tdata,
    input  logic [5:0]                    s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic                          tx_mclk,
    output logic                          tx_sclk,
    output logic                          tx_lrck,
    output logic                          tx_sdout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          misalign
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(MCLK_PER_SCLK * SCLK_PER_FRAME);
    localparam int SUB_W = $clog2(MCLK_PER_SCLK);

    localparam logic signed [IN_WIDTH:0] ROUND_BIAS =
        {{(IN_WIDTH-FRAC_SHIFT+1){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
    localparam logic signed [IN_WIDTH:0] SAT_MAX =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic                   ready_q;
    logic [CNT_W-1:0]       cnt;
    sample_t                hold_l;
    sample_t                hold_r;
    logic [SAMPLE_W-1:0]    shreg;
    logic                   sdout_q;
    logic                   underrun_q;
    logic                   misalign_q;

    logic                   push;
    logic [1:0]             pop_cnt;
    fifo_entry_t            push_data;
    fifo_entry_t            head;
    fifo_entry_t            next_entry;
    logic [LVL_W-1:0]       level;

    logic signed [IN_WIDTH:0] rq_sum;
    logic signed [IN_WIDTH:0] rq_shift;
    sample_t                rq_sample;

    logic                   frame_start;
    logic                   take_pair;
    logic                   und_set;
    logic                   mis_set;
    logic                   unused_keep;

    assign unused_keep   = ^s_axis_tkeep;
    assign s_axis_tready = ready_q && (level != LVL_W'(FIFO_DEPTH));
    assign push          = s_axis_tvalid && s_axis_tready;

    // Round half up at one extra bit of headroom, then clamp to the DAC range.
    always_comb begin
        rq_sum   = $signed({s_axis_tdata[IN_WIDTH-1], s_axis_tdata}) + ROUND_BIAS;
        rq_shift = rq_sum >>> FRAC_SHIFT;
        if (rq_shift > SAT_MAX) begin
            rq_sample = SAT_MAX[SAMPLE_W-1:0];
        end else if (rq_shift < SAT_MIN) begin
            rq_sample = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            rq_sample = rq_shift[SAMPLE_W-1:0];
        end
        push_data.tlast  = s_axis_tlast;
        push_data.sample = rq_sample;
    end

    axis_sample_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop_cnt    (pop_cnt),
        .head       (head),
        .next_entry (next_entry),
        .level      (level)
    );

    assign frame_start = (cnt == CNT_W'(FRAME_CLKS-1));

    // A stray right sample at the head is dropped alone so the stream resyncs.
    always_comb begin
        pop_cnt   = 2'd0;
        take_pair = 1'b0;
        und_set   = 1'b0;
        mis_set   = 1'b0;
        if (frame_start) begin
            if ((level >= LVL_W'(2)) && !head.tlast && next_entry.tlast) begin
                pop_cnt   = 2'd2;
                take_pair = 1'b1;
            end else if ((level != '0) && head.tlast) begin
                pop_cnt = 2'd1;
                mis_set = 1'b1;
            end else begin
                und_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q    <= 1'b0;
            cnt        <= '0;
            hold_l     <= '0;
            hold_r     <= '0;
            underrun_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            cnt        <= cnt + CNT_W'(1);
            underrun_q <= und_set;
            misalign_q <= mis_set;
            if (frame_start) begin
                hold_l <= take_pair ? head.sample       : '0;
                hold_r <= take_pair ? next_entry.sample : '0;
            end
        end
    end

    // Loading drives the MSB out on the same SCLK falling edge as the load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdout_q <= 1'b0;
            shreg   <= '0;
        end else if (cnt == CNT_W'(LOAD_L-1)) begin
            {sdout_q, shreg} <= {hold_l, 1'b0};
        end else if (cnt == CNT_W'(LOAD_R-1)) begin
            {sdout_q, shreg} <= {hold_r, 1'b0};
        end else if (cnt[SUB_W-1:0] == SUB_W'(MCLK_PER_SCLK-1)) begin
            {sdout_q, shreg} <= {shreg, 1'b0};
        end
    end

    assign tx_mclk    = clk;
    assign tx_sclk    = cnt[SUB_W-1];
    assign tx_lrck    = cnt[CNT_W-1];
    assign tx_sdout   = sdout_q;
    assign fifo_level = level;
    assign underrun   = underrun_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Self-checking bench for axis_i2s_tx against a queue-based frame model.
module tb_axis_i2s_tx;

    localparam int IN_W  = 52;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [IN_W-1:0] s_axis_tdata = '0;
    logic [5:0]      s_axis_tkeep = 6'h3f;
    logic            s_axis_tlast = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic            tx_mclk;
    logic            tx_sclk;
    logic            tx_lrck;
    logic            tx_sdout;
    logic [3:0]      fifo_level;
    logic            underrun;
    logic            misalign;

    always #5 clk = ~clk;

    axis_i2s_tx #(
        .IN_WIDTH      (52),
        .OUT_WIDTH     (24),
        .FRAC_SHIFT    (23),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .tx_mclk       (tx_mclk),
        .tx_sclk       (tx_sclk),
        .tx_lrck       (tx_lrck),
        .tx_sdout      (tx_sdout),
        .fifo_level    (fifo_level),
        .underrun      (underrun),
        .misalign      (misalign)
    );

    typedef struct {
        bit          last;
        logic [23:0] s;
    } ent_t;

    ent_t        q[$];
    int          mcnt = 0;
    bit          mready = 0;
    logic [23:0] m_l = '0;
    logic [23:0] m_r = '0;
    bit          exp_und = 0;
    bit          exp_mis = 0;
    bit          accepted = 0;
    logic [23:0] cap_l = '0;
    logic [23:0] cap_r = '0;
    int          n_assert = 0;
    int          n_fail = 0;

    function automatic logic [23:0] requant(longint x);
        longint r;
        r = (x + (longint'(1) << 22)) >>> 23;
        if (r > 64'sd8388607) r = 64'sd8388607;
        else if (r < -64'sd8388608) r = -64'sd8388608;
        return r[23:0];
    endfunction

    // Expected serial bit at frame position p (value after the edge).
    function automatic bit expBit(int p);
        int k;
        if (p >= 4 && p < 100) begin
            k = (p - 4) / 4;
            if (k < 24) return m_l[23-k];
        end else if (p >= 132 && p < 228) begin
            k = (p - 132) / 4;
            if (k < 24) return m_r[23-k];
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mcnt    = 0;
        mready  = 0;
        m_l     = '0;
        m_r     = '0;
        exp_und = 0;
        exp_mis = 0;
    endtask

    task automatic tick();
        bit   exp_ready;
        bit   push;
        ent_t e;
        exp_ready = mready && (q.size() != DEPTH);
        checkOutput("tready", s_axis_tready, exp_ready);
        push   = s_axis_tvalid && exp_ready && !reset;
        e.last = s_axis_tlast;
        e.s    = requant(longint'($signed(s_axis_tdata)));
        exp_und = 0;
        exp_mis = 0;
        if (!reset && mcnt == 255) begin
            if (q.size() >= 2 && !q[0].last && q[1].last) begin
                m_l = q[0].s;
                m_r = q[1].s;
                void'(q.pop_front());
                void'(q.pop_front());
            end else if (q.size() >= 1 && q[0].last) begin
                m_l = '0;
                m_r = '0;
                void'(q.pop_front());
                exp_mis = 1;
            end else begin
                m_l = '0;
                m_r = '0;
                exp_und = 1;
            end
        end
        if (push) q.push_back(e);
        accepted = push;
        @(posedge clk);
        if (!reset) begin
            mcnt   = (mcnt + 1) % 256;
            mready = 1;
        end
        #1;
        checkOutput("level", fifo_level, q.size());
        checkOutput("sclk", tx_sclk, (mcnt >> 1) & 1);
        checkOutput("lrck", tx_lrck, (mcnt >> 7) & 1);
        checkOutput("sdout", tx_sdout, expBit(mcnt));
        checkOutput("underrun", underrun, exp_und);
        checkOutput("misalign", misalign, exp_mis);
        if (mcnt == 0) begin
            cap_l = '0;
            cap_r = '0;
        end
        if (mcnt >= 4 && mcnt < 100 && (mcnt % 4) == 2) cap_l = {cap_l[22:0], tx_sdout};
        if (mcnt >= 132 && mcnt < 228 && (mcnt % 4) == 2) cap_r = {cap_r[22:0], tx_sdout};
    endtask

    task automatic applyStimulus(input longint x, input bit last);
        s_axis_tdata  = x[IN_W-1:0];
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (accepted) break;
        end
        checkOutput("push_accept", accepted, 1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic runTo(input int target);
        for (int i = 0; i < 600 && mcnt != target; i++) tick();
        checkOutput("run_to", mcnt, target);
    endtask

    task automatic checkFrame(input string tag, input logic [23:0] l, input logic [23:0] r);
        runTo(255);
        tick();
        runTo(230);
        checkOutput({tag, "_left"}, cap_l, l);
        checkOutput({tag, "_right"}, cap_r, r);
    endtask

    function automatic longint randWord();
        longint x;
        x = longint'($signed({$urandom, $urandom})) >>> $urandom_range(12, 36);
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint one;
        longint wl[5];
        longint wr[5];
        one = 1;

        #1 reset = 1'b1;
        #3;
        checkOutput("rst_tready", s_axis_tready, 0);
        checkOutput("rst_sclk", tx_sclk, 0);
        checkOutput("rst_lrck", tx_lrck, 0);
        checkOutput("rst_sdout", tx_sdout, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_underrun", underrun, 0);
        checkOutput("rst_misalign", misalign, 0);
        modelReset();
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("ready_rise", s_axis_tready, 1);

        $display("[TB] basic stereo frame");
        applyStimulus(longint'(24'h123456) << 23, 0);
        applyStimulus(longint'(24'h654321) << 23, 1);
        checkFrame("basic", 24'h123456, 24'h654321);

        $display("[TB] rounding and saturation");
        applyStimulus((one << 25) + (one << 23) + (one << 22), 0);
        applyStimulus(-((one << 25) + (one << 23)) - (one << 22), 1);
        checkFrame("round", 24'h000006, 24'hFFFFFB);
        applyStimulus((one << 25) + (one << 23) + (one << 22) - 1, 0);
        applyStimulus(one << 50, 1);
        checkFrame("round_sat", 24'h000005, 24'h7FFFFF);
        applyStimulus(-(one << 50), 0);
        applyStimulus(0, 1);
        checkFrame("sat_neg", 24'h800000, 24'h000000);

        $display("[TB] underrun and misalign");
        runTo(255);
        tick();
        checkOutput("underrun_pulse", underrun, 1);
        runTo(230);
        checkOutput("silent_left", cap_l, 0);
        checkOutput("silent_right", cap_r, 0);
        applyStimulus(randWord(), 1);
        applyStimulus(longint'(24'h0ABCDE) << 23, 0);
        applyStimulus(longint'(24'h13579B) << 23, 1);
        runTo(255);
        tick();
        checkOutput("misalign_pulse", misalign, 1);
        runTo(230);
        checkOutput("misalign_silent", cap_l | cap_r, 0);
        checkFrame("after_misalign", 24'h0ABCDE, 24'h13579B);

        $display("[TB] backpressure with 10 queued words");
        runTo(10);
        for (int i = 0; i < 5; i++) begin
            wl[i] = randWord();
            wr[i] = randWord();
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(wl[i], 0);
            applyStimulus(wr[i], 1);
            if (i == 3) begin
                checkOutput("full_level", fifo_level, 8);
                checkOutput("full_tready", s_axis_tready, 0);
            end
        end
        runTo(230);
        checkOutput("bp0_left", cap_l, requant(wl[0]));
        checkOutput("bp0_right", cap_r, requant(wr[0]));
        for (int i = 1; i < 5; i++) begin
            checkFrame("bp", requant(wl[i]), requant(wr[i]));
        end

        $display("[TB] reset mid-frame");
        runTo(5);
        for (int i = 0; i < 5; i++) applyStimulus(randWord(), (i % 2) == 1);
        runTo(70);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_tready", s_axis_tready, 0);
        checkOutput("mid_rst_sclk", tx_sclk, 0);
        checkOutput("mid_rst_lrck", tx_lrck, 0);
        checkOutput("mid_rst_sdout", tx_sdout, 0);
        checkOutput("mid_rst_level", fifo_level, 0);
        checkOutput("mid_rst_underrun", underrun, 0);
        checkOutput("mid_rst_misalign", misalign, 0);
        modelReset();
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("mid_rst_ready_rise", s_axis_tready, 1);
        checkOutput("mid_rst_cnt_restart", {tx_lrck, tx_sclk}, 2'b00);
        applyStimulus(longint'(24'h00F00F) << 23, 0);
        applyStimulus(longint'(24'h7A5A5A) << 23, 1);
        checkFrame("post_reset", 24'h00F00F, 24'h7A5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
